// File: rtl/tile_loader_c1w4h4_if.sv
// Stream-in / tile-out bundle for the 4x4 single-channel tile loader.
// slave  : the loader itself (consumes pixels, produces the tile).
// master : the environment (pixel source and tile consumer).
interface tile_loader_c1w4h4_if #(
  parameter int BITWIDTH = 1
);
  // Pixel stream side
  logic signed [BITWIDTH:0] in_data;
  logic                     in_valid;
  logic                     in_last;
  logic                     in_ready;

  // Tile side, xRC = row R, column C
  logic signed [BITWIDTH:0] x00, x01, x02, x03;
  logic signed [BITWIDTH:0] x10, x11, x12, x13;
  logic signed [BITWIDTH:0] x20, x21, x22, x23;
  logic signed [BITWIDTH:0] x30, x31, x32, x33;
  logic                     tile_valid;
  logic                     tile_ready;

  // Status
  logic                     err;
  logic [7:0]               tile_cnt;

  modport slave (
    input  in_data, in_valid, in_last, tile_ready,
    output in_ready, tile_valid, err, tile_cnt,
    output x00, x01, x02, x03, x10, x11, x12, x13,
    output x20, x21, x22, x23, x30, x31, x32, x33
  );

  modport master (
    output in_data, in_valid, in_last, tile_ready,
    input  in_ready, tile_valid, err, tile_cnt,
    input  x00, x01, x02, x03, x10, x11, x12, x13,
    input  x20, x21, x22, x23, x30, x31, x32, x33
  );
endinterface

// File: rtl/tile_loader_c1w4h4.sv
// Tile loader: assembles 16 raster-order pixels into a 4x4 tile for the
// 2x2-kernel conv stage, with framing-error detection and a tile counter.
// Optional macro TILE_LOADER_DBUF_EN adds a shadow bank so the next tile can
// stream in while the current one is still held (back-to-back tiles).
module tile_loader_c1w4h4 #(
  parameter int BITWIDTH = 1
) (
  input  logic                clk_en,
  input  logic                rst_n,
  input  logic                clear,
  tile_loader_c1w4h4_if.slave bus
);

  typedef enum logic {FILL = 1'b0, HOLD = 1'b1} state_t;

  state_t                   state_q;
  logic [3:0]               pix_cnt_q;
  logic signed [BITWIDTH:0] x_q [16];
  logic                     err_q;
  logic [7:0]               tile_cnt_q;

  logic in_ready_w;
  logic tile_valid_w;
  logic xfer;
  logic hs;
  logic early_last;
  logic last_beat;

`ifdef TILE_LOADER_DBUF_EN
  // Pixels are always assembled in the shadow bank; the front bank (x_q) is
  // only ever loaded with a complete tile, so the consumer never sees a
  // partially overwritten tile.
  logic signed [BITWIDTH:0] sh_q [16];
  logic signed [BITWIDTH:0] load_w [16];
  logic                     sh_full_q;

  assign in_ready_w = ~sh_full_q;

  // Tile to present next: the shadow bank, with the final pixel bypassed in
  // when it arrives on the same edge the front bank is loaded.
  for (genvar gi = 0; gi < 16; gi++) begin : g_load
    if (gi == 15) begin : g_tail
      assign load_w[gi] = last_beat ? bus.in_data : sh_q[gi];
    end else begin : g_body
      assign load_w[gi] = sh_q[gi];
    end
  end
`else
  assign in_ready_w = (state_q == FILL);
`endif

  assign tile_valid_w   = (state_q == HOLD);
  assign bus.in_ready   = in_ready_w;
  assign bus.tile_valid = tile_valid_w;
  assign bus.err        = err_q;
  assign bus.tile_cnt   = tile_cnt_q;

  assign bus.x00 = x_q[0];
  assign bus.x01 = x_q[1];
  assign bus.x02 = x_q[2];
  assign bus.x03 = x_q[3];
  assign bus.x10 = x_q[4];
  assign bus.x11 = x_q[5];
  assign bus.x12 = x_q[6];
  assign bus.x13 = x_q[7];
  assign bus.x20 = x_q[8];
  assign bus.x21 = x_q[9];
  assign bus.x22 = x_q[10];
  assign bus.x23 = x_q[11];
  assign bus.x30 = x_q[12];
  assign bus.x31 = x_q[13];
  assign bus.x32 = x_q[14];
  assign bus.x33 = x_q[15];

  // Handshake decode: a beat that ends a tile early aborts it, the 16th beat completes it.
  always_comb begin
    xfer       = bus.in_valid & in_ready_w;
    hs         = tile_valid_w & bus.tile_ready;
    early_last = xfer & bus.in_last & (pix_cnt_q != 4'd15);
    last_beat  = xfer & (pix_cnt_q == 4'd15);
  end

  // Loader FSM, pixel banks, error flag and tile counter.
  always_ff @(posedge clk_en or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= FILL;
      pix_cnt_q  <= 4'd0;
      err_q      <= 1'b0;
      tile_cnt_q <= 8'd0;
      for (int i = 0; i < 16; i++) begin
        x_q[i] <= '0;
      end
`ifdef TILE_LOADER_DBUF_EN
      sh_full_q <= 1'b0;
      for (int i = 0; i < 16; i++) begin
        sh_q[i] <= '0;
      end
`endif
    end else if (clear) begin
      // Flush wins over everything; any beat or handshake this cycle is dropped.
      state_q   <= FILL;
      pix_cnt_q <= 4'd0;
      err_q     <= 1'b0;
`ifdef TILE_LOADER_DBUF_EN
      sh_full_q <= 1'b0;
`endif
    end else begin
      if (early_last) begin
        // Short tile: discard it and restart from pixel 0.
        err_q     <= 1'b1;
        pix_cnt_q <= 4'd0;
      end else if (xfer) begin
`ifdef TILE_LOADER_DBUF_EN
        sh_q[pix_cnt_q] <= bus.in_data;
`else
        x_q[pix_cnt_q]  <= bus.in_data;
`endif
        // 4-bit counter wraps 15 -> 0 at the end of a tile.
        pix_cnt_q <= pix_cnt_q + 4'd1;
        if (last_beat && !bus.in_last) begin
          err_q <= 1'b1;
        end
      end

      if (hs) begin
        tile_cnt_q <= tile_cnt_q + 8'd1;
      end

`ifdef TILE_LOADER_DBUF_EN
      if (hs) begin
        if (sh_full_q || last_beat) begin
          // Next tile is ready: swap it in, tile_valid stays high.
          for (int i = 0; i < 16; i++) begin
            x_q[i] <= load_w[i];
          end
          sh_full_q <= 1'b0;
        end else begin
          state_q <= FILL;
        end
      end else if (last_beat) begin
        if (state_q == HOLD) begin
          sh_full_q <= 1'b1;
        end else begin
          for (int i = 0; i < 16; i++) begin
            x_q[i] <= load_w[i];
          end
          state_q <= HOLD;
        end
      end
`else
      if (last_beat) begin
        state_q <= HOLD;
      end else if (hs) begin
        state_q <= FILL;
      end
`endif
    end
  end

endmodule
